// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM state encoding and
// a helper that classifies the multi-cycle operations.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd11;
    localparam logic [OP_W-1:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL and DIVU go through the iterative datapath
    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_unit_if.sv
// Request/response bundle between the EX stage and alu_iter_unit.
//   master: drives Start, ALUControl, A, B, Shamt; sees the results
//   slave : the ALU; drives ALUResult, Hi, Zero, Busy, Done, DivByZero
interface alu_iter_unit_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
    logic                      Start;
    logic [alu_pkg::OP_W-1:0]  ALUControl;
    logic [WIDTH-1:0]          A;
    logic [WIDTH-1:0]          B;
    logic [SHAMT_W-1:0]        Shamt;
    logic [WIDTH-1:0]          ALUResult;
    logic [WIDTH-1:0]          Hi;
    logic                      Zero;
    logic                      Busy;
    logic                      Done;
    logic                      DivByZero;

    modport master (
        output Start, ALUControl, A, B, Shamt,
        input  ALUResult, Hi, Zero, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, ALUControl, A, B, Shamt,
        output ALUResult, Hi, Zero, Busy, Done, DivByZero
    );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*WIDTH shift register and one adder/subtractor. One step per cycle for
// WIDTH cycles after Load.
//   Clk, Reset : clock, synchronous active-high reset
//   Load, IsDiv: start a new operation (divide when IsDiv), operands A, B
//   Hi, Lo     : product high/low, or remainder/quotient
//   Last       : high during the cycle whose edge performs the final step
module iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             IsDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Last
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = WIDTH + 2;

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             div_q;
    logic             active_q;
    logic [CNT_W-1:0] cnt_q;

    logic [ACC_W-1:0] op_a, op_b, sum;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             last_c;

    assign last_c = active_q && (cnt_q == CNT_W'(WIDTH - 1));

    // One step: multiply adds B into the upper half then shifts right;
    // divide shifts left and subtracts B, restoring when the trial goes negative.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (div_q) begin
            op_a = {1'b0, hi_q, lo_q[WIDTH-1]};
            op_b = ~{2'b00, b_q};
        end else begin
            op_a = {2'b00, hi_q};
            op_b = lo_q[0] ? {2'b00, b_q} : '0;
        end
        sum = op_a + op_b + ACC_W'(div_q);

        hi_d = {sum[WIDTH:1]};
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (!sum[ACC_W-1]) begin
                hi_d = sum[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (Load) begin
            hi_q     <= '0;
            lo_q     <= A;
            b_q      <= B;
            div_q    <= IsDiv;
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
                active_q <= 1'b0;
            end
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Last = last_c;

endmodule

// File: rtl/alu_iter_unit.sv
// EX-stage ALU: single-cycle logic/shift/compare ops with a registered
// Start/Done handshake, plus iterative MUL and DIVU producing Hi/Lo.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of alu_iter_unit_if (request in, results out)
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic      Clk,
    input  logic      Reset,
    alu_iter_unit_if.slave bus
);
    state_t state_q, state_d;

    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   alu_c;
    logic [SHAMT_W-1:0] shamt;
    logic               md_load, md_is_div, md_last;
    logic [WIDTH-1:0]   md_hi, md_lo;

    assign shamt = bus.Shamt;

    // Single-cycle result mux; MUL/DIVU and illegal codes yield zero here
    always_comb begin
        alu_c = '0;
        case (bus.ALUControl)
            OP_ADD:  alu_c = bus.A + bus.B;
            OP_SUB:  alu_c = bus.A - bus.B;
            OP_AND:  alu_c = bus.A & bus.B;
            OP_OR:   alu_c = bus.A | bus.B;
            OP_NOR:  alu_c = ~(bus.A | bus.B);
            OP_XOR:  alu_c = bus.A ^ bus.B;
            OP_SLL:  alu_c = bus.B << shamt;
            OP_SRL:  alu_c = bus.B >> shamt;
            OP_SRA:  alu_c = $unsigned($signed(bus.B) >>> shamt);
            OP_SLT:  alu_c = WIDTH'($signed(bus.A) < $signed(bus.B));
            OP_SLTU: alu_c = WIDTH'(bus.A < bus.B);
            default: alu_c = '0;
        endcase
    end

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (md_load),
        .IsDiv (md_is_div),
        .A     (bus.A),
        .B     (bus.B),
        .Hi    (md_hi),
        .Lo    (md_lo),
        .Last  (md_last)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        busy_d    = 1'b0;
        md_load   = 1'b0;
        md_is_div = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if ((bus.ALUControl == OP_DIVU) && (bus.B == '0)) begin
                        // divide by zero resolves immediately without iterating
                        result_d = '1;
                        hi_d     = bus.A;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else if (is_multi(bus.ALUControl)) begin
                        md_load   = 1'b1;
                        md_is_div = (bus.ALUControl == OP_DIVU);
                        state_d   = ST_RUN;
                    end else begin
                        result_d = alu_c;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (md_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_d = md_lo;
                hi_d     = md_hi;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.Hi        = hi_q;
    assign bus.Zero      = (result_q == '0);
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Bench for alu_iter_unit at WIDTH=32 and WIDTH=8 side by side, checked every
// cycle against an arithmetic reference model of the request/result timing.
module tb_alu_iter_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_unit_if #(.WIDTH(32)) bus32();
    alu_iter_unit_if #(.WIDTH(8))  bus8();

    alu_iter_unit #(.WIDTH(32)) dut32 (.Clk(clk), .Reset(rst), .bus(bus32));
    alu_iter_unit #(.WIDTH(8))  dut8  (.Clk(clk), .Reset(rst), .bus(bus8));

    int checks = 0;
    int errors = 0;

    int               wid [2] = '{32, 8};
    longint unsigned  m_res [2];
    longint unsigned  m_hi  [2];
    longint unsigned  p_res [2];
    longint unsigned  p_hi  [2];
    bit               m_busy[2];
    bit               m_done[2];
    bit               m_dbz [2];
    int               m_cnt [2];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic longint unsigned msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sval(input int w, input longint unsigned v);
        if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - longint'(64'd1 << w);
        return longint'(v);
    endfunction

    // Result of a single-cycle opcode from plain arithmetic
    function automatic longint unsigned ref_single(input int w, input logic [3:0] op,
                                                   input longint unsigned a, input longint unsigned b,
                                                   input int sh);
        longint unsigned m = msk(w);
        longint unsigned r;
        case (op)
            4'd0:  return (a + b) & m;
            4'd1:  return (a - b) & m;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return ~(a | b) & m;
            4'd5:  return a ^ b;
            4'd6:  return (b << sh) & m;
            4'd7:  return b >> sh;
            4'd9:  return (sval(w, a) < sval(w, b)) ? 64'd1 : 64'd0;
            4'd10: begin
                r = b >> sh;
                if (((b >> (w - 1)) & 64'd1) != 0) r = r | ((m << (w - sh)) & m);
                return r;
            end
            4'd11: return (a < b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    // Advance the reference by one clock edge given the sampled request
    task automatic model_step(input int k, input bit st, input logic [3:0] op,
                              input longint unsigned a, input longint unsigned b, input int sh);
        int w = wid[k];
        longint unsigned prod;
        if (rst) begin
            m_res[k] = 0; m_hi[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_dbz[k] = 0; m_cnt[k] = 0;
        end else if (m_busy[k]) begin
            m_done[k] = 0; m_dbz[k] = 0;
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
                m_busy[k] = 0; m_done[k] = 1; m_res[k] = p_res[k]; m_hi[k] = p_hi[k];
            end
        end else begin
            m_done[k] = 0; m_dbz[k] = 0;
            if (st) begin
                if (op == 4'd12 && b == 0) begin
                    m_res[k] = msk(w); m_hi[k] = a; m_dbz[k] = 1; m_done[k] = 1;
                end else if (op == 4'd8) begin
                    prod = a * b;
                    p_res[k] = prod & msk(w); p_hi[k] = (prod >> w) & msk(w);
                    m_busy[k] = 1; m_cnt[k] = w + 1;
                end else if (op == 4'd12) begin
                    p_res[k] = a / b; p_hi[k] = a % b;
                    m_busy[k] = 1; m_cnt[k] = w + 1;
                end else begin
                    m_res[k] = ref_single(w, op, a, b, sh); m_done[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp_unit(input int k, input longint unsigned res, input longint unsigned hi,
                            input bit busy, input bit done, input bit dbz, input bit zero);
        chk($sformatf("u%0d_result", wid[k]), res, m_res[k]);
        chk($sformatf("u%0d_hi", wid[k]), hi, m_hi[k]);
        chk($sformatf("u%0d_busy", wid[k]), 64'(busy), 64'(m_busy[k]));
        chk($sformatf("u%0d_done", wid[k]), 64'(done), 64'(m_done[k]));
        chk($sformatf("u%0d_zero", wid[k]), 64'(zero), (m_res[k] == 0) ? 64'd1 : 64'd0);
        if (m_done[k]) chk($sformatf("u%0d_divbyzero", wid[k]), 64'(dbz), 64'(m_dbz[k]));
    endtask

    // One clock: model follows the edge, then every output is compared
    task automatic tick();
        @(posedge clk);
        model_step(0, bus32.Start, bus32.ALUControl, 64'(bus32.A), 64'(bus32.B), int'(bus32.Shamt));
        model_step(1, bus8.Start,  bus8.ALUControl,  64'(bus8.A),  64'(bus8.B),  int'(bus8.Shamt));
        #1;
        cmp_unit(0, 64'(bus32.ALUResult), 64'(bus32.Hi), bus32.Busy, bus32.Done, bus32.DivByZero, bus32.Zero);
        cmp_unit(1, 64'(bus8.ALUResult),  64'(bus8.Hi),  bus8.Busy,  bus8.Done,  bus8.DivByZero,  bus8.Zero);
    endtask

    task automatic drive32(input bit st, input logic [3:0] op, input longint unsigned a,
                           input longint unsigned b, input int sh);
        bus32.Start = st; bus32.ALUControl = op; bus32.A = 32'(a); bus32.B = 32'(b); bus32.Shamt = 5'(sh);
    endtask

    task automatic drive8(input bit st, input logic [3:0] op, input longint unsigned a,
                          input longint unsigned b, input int sh);
        bus8.Start = st; bus8.ALUControl = op; bus8.A = 8'(a); bus8.B = 8'(b); bus8.Shamt = 3'(sh);
    endtask

    task automatic run1(input logic [3:0] op, input longint unsigned a, input longint unsigned b, input int sh);
        drive32(1'b1, op, a, b, sh);
        tick();
        bus32.Start = 1'b0;
    endtask

    // Issue a multi-cycle op on both units; report Done latency and Busy cycles
    task automatic multi(input logic [3:0] op, input longint unsigned a32, input longint unsigned b32,
                         input longint unsigned a8, input longint unsigned b8, input bit inject,
                         output int d32, output int d8, output int bz32, output int bz8);
        d32 = -1; d8 = -1; bz32 = 0; bz8 = 0;
        drive32(1'b1, op, a32, b32, 0);
        drive8(1'b1, op, a8, b8, 0);
        tick();
        bus32.Start = 1'b0; bus8.Start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (inject && (n == 3 || n == 20)) drive32(1'b1, OP_SUB, 64'h1234, 64'h1, 3);
            if (inject && n == 3) drive8(1'b1, OP_ADD, 1, 2, 0);
            tick();
            bus32.Start = 1'b0; bus8.Start = 1'b0;
            if (bus32.Busy) bz32++;
            if (bus8.Busy) bz8++;
            if (bus32.Done && d32 < 0) d32 = n;
            if (bus8.Done && d8 < 0) d8 = n;
            if (d32 >= 0 && d8 >= 0) break;
        end
    endtask

    initial begin
        int d32, d8, bz32, bz8, ndone;
        logic [3:0] op;
        int r;
        longint unsigned a, b;

        rst = 1'b1;
        drive32(1'b0, OP_ADD, 0, 0, 0);
        drive8(1'b0, OP_ADD, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_result", 64'(bus32.ALUResult), 64'd0);
        chk("reset_hi", 64'(bus32.Hi), 64'd0);
        chk("reset_zero", 64'(bus32.Zero), 64'd1);
        chk("reset_busy", 64'(bus32.Busy), 64'd0);
        chk("reset_done", 64'(bus32.Done), 64'd0);
        chk("reset_dbz", 64'(bus32.DivByZero), 64'd0);
        tick();

        // wraparound ADD
        run1(OP_ADD, 64'hFFFF_FFFF, 64'd1, 0);
        chk("add_wrap_done", 64'(bus32.Done), 64'd1);
        chk("add_wrap_result", 64'(bus32.ALUResult), 64'd0);
        chk("add_wrap_zero", 64'(bus32.Zero), 64'd1);
        chk("add_wrap_busy", 64'(bus32.Busy), 64'd0);
        tick();
        chk("add_done_pulse", 64'(bus32.Done), 64'd0);

        run1(OP_SLT, 64'hFFFF_FFFE, 64'd1, 0);
        chk("slt_neg", 64'(bus32.ALUResult), 64'd1);
        run1(OP_SLTU, 64'hFFFF_FFFE, 64'd1, 0);
        chk("sltu_big", 64'(bus32.ALUResult), 64'd0);
        run1(OP_SRA, 64'd0, 64'h8000_0000, 4);
        chk("sra_sign", 64'(bus32.ALUResult), 64'hF800_0000);
        run1(4'd14, 64'd3, 64'd4, 0);
        chk("illegal_result", 64'(bus32.ALUResult), 64'd0);
        chk("illegal_done", 64'(bus32.Done), 64'd1);

        // MUL on both widths with ignored Starts during RUN
        multi(OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFF, 64'hFF, 1'b1, d32, d8, bz32, bz8);
        chk("mul32_latency", 64'(d32), 64'd33);
        chk("mul8_latency", 64'(d8), 64'd9);
        chk("mul32_busy_cycles", 64'(bz32), 64'd32);
        chk("mul8_busy_cycles", 64'(bz8), 64'd8);
        chk("mul32_hi", 64'(bus32.Hi), 64'hFFFF_FFFE);
        chk("mul32_lo", 64'(bus32.ALUResult), 64'h1);
        chk("mul8_hi", 64'(bus8.Hi), 64'hFE);
        chk("mul8_lo", 64'(bus8.ALUResult), 64'h01);

        // reset during RUN aborts
        drive32(1'b1, OP_MUL, 64'h1234_5678, 64'h9ABC_DEF0, 0);
        drive8(1'b1, OP_DIVU, 64'hC8, 64'h07, 0);
        tick();
        bus32.Start = 1'b0; bus8.Start = 1'b0;
        for (int n = 0; n < 9; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(bus32.Busy), 64'd0);
        chk("abort_done", 64'(bus32.Done), 64'd0);
        chk("abort_hi", 64'(bus32.Hi), 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus32.Done || bus8.Done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // DIVU
        multi(OP_DIVU, 64'd100, 64'd7, 64'd200, 64'd7, 1'b0, d32, d8, bz32, bz8);
        chk("divu32_latency", 64'(d32), 64'd33);
        chk("divu32_quot", 64'(bus32.ALUResult), 64'd14);
        chk("divu32_rem", 64'(bus32.Hi), 64'd2);
        chk("divu8_quot", 64'(bus8.ALUResult), 64'd28);
        chk("divu8_rem", 64'(bus8.Hi), 64'd4);

        drive32(1'b1, OP_DIVU, 64'd5, 64'd0, 0);
        drive8(1'b1, OP_DIVU, 64'd9, 64'd0, 0);
        tick();
        bus32.Start = 1'b0; bus8.Start = 1'b0;
        chk("div0_done", 64'(bus32.Done), 64'd1);
        chk("div0_result", 64'(bus32.ALUResult), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(bus32.Hi), 64'd5);
        chk("div0_flag", 64'(bus32.DivByZero), 64'd1);
        chk("div0_busy", 64'(bus32.Busy), 64'd0);
        chk("div0_8_result", 64'(bus8.ALUResult), 64'hFF);
        chk("div0_8_hi", 64'(bus8.Hi), 64'd9);

        // Start in the Done cycle is accepted
        multi(OP_MUL, 64'd3, 64'd5, 64'd7, 64'd9, 1'b0, d32, d8, bz32, bz8);
        chk("b2b_mul_done", 64'(bus32.Done), 64'd1);
        run1(OP_ADD, 64'd10, 64'd20, 0);
        chk("b2b_accept_done", 64'(bus32.Done), 64'd1);
        chk("b2b_accept_result", 64'(bus32.ALUResult), 64'd30);
        chk("b2b_hi_held", 64'(bus32.Hi), 64'd0);

        // randomized traffic, including back-to-back single-cycle ops
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                r = $urandom_range(0, 19);
                op = (r < 16) ? 4'(r) : ((r < 18) ? OP_MUL : OP_DIVU);
                a = 64'($urandom);
                b = 64'($urandom);
                if ($urandom_range(0, 7) == 0) b = 0;
                if ($urandom_range(0, 3) == 0) a = a & 64'hF;
                if (k == 0) drive32(($urandom_range(0, 2) != 0), op, a, b, $urandom_range(0, 31));
                else        drive8(($urandom_range(0, 2) != 0), op, a, b, $urandom_range(0, 7));
            end
            tick();
        end
        rst = 1'b0;
        bus32.Start = 1'b0; bus8.Start = 1'b0;
        for (int n = 0; n < 40; n++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
